// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants and the masked pattern-compare helper for
//                the parametrised serial sequence detector.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_det_pkg;

    // Widest pattern the detector supports; the compare helper works at this
    // width and narrower patterns are zero-extended into it.
    localparam int c_MAX_PAT_W = 32;

    typedef logic [c_MAX_PAT_W-1:0] pat_word_t;

    // Values loaded into the configuration registers at reset.
    localparam logic [3:0] c_DEFAULT_PAT     = 4'b1010;
    localparam logic       c_DEFAULT_OVERLAP = 1'b1;
    // The reset mask is all ones at the chosen pattern width; the top module
    // builds it from its own PAT_W.

    // A window matches when every compared (mask=1) bit equals the pattern.
    // Zero-extended upper bits carry mask=0 and so never affect the result.
    function automatic logic f_pat_match(input pat_word_t hist,
                                         input pat_word_t pattern,
                                         input pat_word_t mask);
        return (((hist ^ pattern) & mask) == '0);
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at its maximum value.
//                Clear has priority over increment.
//  Ports       : clk      - rising-edge clock
//                rst      - synchronous active-low reset
//                i_inc    - increment request
//                i_clr    - clear to zero (wins over i_inc)
//                o_count  - current count
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Serial pattern detector with elaboration-time width and
//                runtime-loadable pattern, don't-care mask and overlap mode.
//                Emits a registered one-cycle pulse per match and keeps a
//                saturating match count.
//  Ports       : clk          - rising-edge clock
//                rst          - synchronous active-low reset
//                x            - serial data bit
//                x_valid      - x is sampled only when high
//                cfg_load     - load cfg_pattern/cfg_mask/cfg_overlap
//                cfg_pattern  - pattern, MSB is the first bit received
//                cfg_mask     - 1 = compare bit, 0 = don't care
//                cfg_overlap  - 1 = overlapping, 0 = non-overlapping
//                cnt_clr      - clear match_count (wins over a match)
//                y            - one-cycle match pulse
//                match_count  - saturating number of matches
//  Revision    : 1.0  initial release
// ============================================================================
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(c_DEFAULT_PAT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             y,
    output logic [CNT_W-1:0] match_count
);

    // fill counts 0..PAT_W inclusive, hence PAT_W+1 distinct values.
    localparam int               FILL_W      = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] c_FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  r_pattern;
    logic [PAT_W-1:0]  r_mask;
    logic              r_overlap;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic              r_y;

    logic [PAT_W-1:0]  w_hist_n;
    logic [FILL_W-1:0] w_fill_n;
    logic              w_match;
    logic              w_cnt_inc;

    // Next window and fill level if the current bit is accepted. A match is
    // only possible once a full window of valid bits has been collected.
    always_comb begin
        w_hist_n = {r_hist[PAT_W-2:0], x};
        w_fill_n = (r_fill == c_FILL_FULL) ? c_FILL_FULL : (r_fill + FILL_W'(1));
        w_match  = (w_fill_n == c_FILL_FULL) &&
                   f_pat_match(pat_word_t'(w_hist_n),
                               pat_word_t'(r_pattern),
                               pat_word_t'(r_mask));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pattern <= DEFAULT_PAT;
            r_mask    <= {PAT_W{1'b1}};
            r_overlap <= c_DEFAULT_OVERLAP;
            r_hist    <= '0;
            r_fill    <= '0;
            r_y       <= 1'b0;
        end else if (cfg_load) begin
            // New configuration restarts the window; the bit on x is dropped.
            r_pattern <= cfg_pattern;
            r_mask    <= cfg_mask;
            r_overlap <= cfg_overlap;
            r_hist    <= '0;
            r_fill    <= '0;
            r_y       <= 1'b0;
        end else if (x_valid) begin
            r_hist <= w_hist_n;
            // In non-overlapping mode emptying fill is enough to force a full
            // fresh window before the next match; hist content is irrelevant.
            r_fill <= (w_match && !r_overlap) ? '0 : w_fill_n;
            r_y    <= w_match;
        end else begin
            r_y <= 1'b0;
        end
    end

    assign w_cnt_inc = x_valid && !cfg_load && w_match;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_cnt_inc),
        .i_clr   (cnt_clr),
        .o_count (match_count)
    );

    assign y = r_y;

endmodule : seq_detector_param
`default_nettype wire
